// File: rtl/npu_sequencer.sv
// Control FSM for one N x N matrix multiply: read addressing, MAC control, output writes, status.
// Optional busy-cycle counter on perf_cycles when NPU_PERF_CNT_EN is defined.
module npu_sequencer #(
  parameter int DATA_WIDTH            = 16,
  parameter int MAX_N                 = 16,
  parameter int INPUT_BUF_ADDR_WIDTH  = 8,
  parameter int WEIGHT_BUF_ADDR_WIDTH = 10,
  parameter int OUTPUT_BUF_ADDR_WIDTH = 8
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic                             ctrl_start,
  input  logic                             ctrl_reset,
  input  logic [7:0]                       ctrl_matrix_size,
  output logic                             in_rd_en,
  output logic [INPUT_BUF_ADDR_WIDTH-1:0]  in_rd_addr,
  output logic                             wt_rd_en,
  output logic [WEIGHT_BUF_ADDR_WIDTH-1:0] wt_rd_addr,
  output logic                             mac_clear,
  output logic                             mac_en,
  output logic                             out_wr_en,
  output logic [OUTPUT_BUF_ADDR_WIDTH-1:0] out_wr_addr,
  output logic                             status_busy,
  output logic                             status_done,
  output logic                             status_error,
  output logic [2:0]                       status_state,
  output logic                             interrupt,
  output logic [31:0]                      perf_cycles
);

  localparam int IW = INPUT_BUF_ADDR_WIDTH;
  localparam int WW = WEIGHT_BUF_ADDR_WIDTH;
  localparam int OW = OUTPUT_BUF_ADDR_WIDTH;

  if (DATA_WIDTH < 1 || MAX_N < 1 || MAX_N > 255) begin : g_param_check
    $error("npu_sequencer: illegal DATA_WIDTH or MAX_N");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t          state, state_nx;
  logic            start_q;
  logic            start_edge;
  logic [7:0]      n_q, i_q, j_q, k_q;
  logic [IW-1:0]   in_base;
  logic [WW-1:0]   wt_base;
  logic [OW-1:0]   out_base;
  logic            rd_vld_p1, clr_vld_p1;
  logic            done_q, error_q;
  logic            rd_en, last_k, last_j, last_i, size_bad;

  assign start_edge = ctrl_start & ~start_q;
  assign last_k     = (k_q == n_q - 8'd1);
  assign last_j     = (j_q == n_q - 8'd1);
  assign last_i     = (i_q == n_q - 8'd1);
  assign size_bad   = (n_q == 8'd0) || (int'(n_q) > MAX_N);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    rd_en        = 1'b0;
    in_rd_addr   = '0;
    wt_rd_addr   = '0;
    out_wr_en    = 1'b0;
    out_wr_addr  = '0;
    status_busy  = 1'b0;
    interrupt    = 1'b0;
    case (state)
      S_IDLE:    if (start_edge) state_nx = S_CHECK;
      S_CHECK: begin
        status_busy = 1'b1;
        state_nx    = size_bad ? S_ERROR : S_COMPUTE;
      end
      S_COMPUTE: begin
        status_busy = 1'b1;
        rd_en       = 1'b1;
        in_rd_addr  = in_base + IW'(k_q);
        wt_rd_addr  = wt_base + WW'(j_q);
        if (last_k) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        status_busy = 1'b1;
        state_nx    = S_WRITE;
      end
      S_WRITE: begin
        status_busy = 1'b1;
        out_wr_en   = 1'b1;
        out_wr_addr = out_base + OW'(j_q);
        state_nx    = (last_i && last_j) ? S_DONE : S_COMPUTE;
      end
      S_DONE, S_ERROR: begin
        interrupt = 1'b1;
        state_nx  = S_IDLE;
      end
      default:   state_nx = S_IDLE;
    endcase
    if (ctrl_reset) state_nx = S_IDLE;
  end

  // Stage p1: read data returns one cycle after the strobe, so MAC controls lag by one.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      start_q    <= 1'b0;
      rd_vld_p1  <= 1'b0;
      clr_vld_p1 <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      n_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      in_base    <= '0;
      wt_base    <= '0;
      out_base   <= '0;
    end else begin
      start_q    <= ctrl_start;
      rd_vld_p1  <= rd_en & ~ctrl_reset;
      clr_vld_p1 <= rd_en & (k_q == 8'd0) & ~ctrl_reset;
      if (ctrl_reset) begin
        done_q  <= 1'b0;
        error_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start_edge) begin
            n_q      <= ctrl_matrix_size;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            in_base  <= '0;
            wt_base  <= '0;
            out_base <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
          end
          S_COMPUTE: begin
            k_q     <= k_q + 8'd1;
            wt_base <= wt_base + WW'(n_q);
          end
          S_WRITE: begin
            k_q     <= '0;
            wt_base <= '0;
            if (last_j) begin
              j_q      <= '0;
              i_q      <= i_q + 8'd1;
              in_base  <= in_base + IW'(n_q);
              out_base <= out_base + OW'(n_q);
            end else begin
              j_q <= j_q + 8'd1;
            end
          end
          default: ;
        endcase
        if (state_nx == S_DONE)  done_q  <= 1'b1;
        if (state_nx == S_ERROR) error_q <= 1'b1;
      end
    end
  end

  assign in_rd_en     = rd_en;
  assign wt_rd_en     = rd_en;
  assign mac_en       = rd_vld_p1;
  assign mac_clear    = clr_vld_p1;
  assign status_done  = done_q;
  assign status_error = error_q;
  assign status_state = state;

`ifdef NPU_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                                perf_q <= '0;
    else if (ctrl_reset)                       perf_q <= '0;
    else if (state == S_IDLE && start_edge)    perf_q <= '0;
    else if (status_busy && perf_q != '1)      perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_npu_sequencer.sv
// Directed bench for npu_sequencer: normal runs, size errors, soft abort, start-level handling, MAX_N.
module tb_npu_sequencer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        ctrl_start;
  logic        ctrl_reset;
  logic [7:0]  ctrl_matrix_size;
  logic        in_rd_en;
  logic [7:0]  in_rd_addr;
  logic        wt_rd_en;
  logic [9:0]  wt_rd_addr;
  logic        mac_clear;
  logic        mac_en;
  logic        out_wr_en;
  logic [7:0]  out_wr_addr;
  logic        status_busy;
  logic        status_done;
  logic        status_error;
  logic [2:0]  status_state;
  logic        interrupt;
  logic [31:0] perf_cycles;

  npu_sequencer dut (
    .aclk             (aclk),
    .areset           (areset),
    .ctrl_start       (ctrl_start),
    .ctrl_reset       (ctrl_reset),
    .ctrl_matrix_size (ctrl_matrix_size),
    .in_rd_en         (in_rd_en),
    .in_rd_addr       (in_rd_addr),
    .wt_rd_en         (wt_rd_en),
    .wt_rd_addr       (wt_rd_addr),
    .mac_clear        (mac_clear),
    .mac_en           (mac_en),
    .out_wr_en        (out_wr_en),
    .out_wr_addr      (out_wr_addr),
    .status_busy      (status_busy),
    .status_done      (status_done),
    .status_error     (status_error),
    .status_state     (status_state),
    .interrupt        (interrupt),
    .perf_cycles      (perf_cycles)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  int in_q[$], wt_q[$], wr_q[$], st_q[$];
  int busy_cnt, rd_cnt, wr_cnt, mac_cnt, clr_cnt, both_cnt, irq_cnt;
  int lag_err, clr_orphan, wt_max, rd_cycle, mac_cycle, timeout;
  int pre_done, first_state, first_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drop start for a cycle, raise it with size n, then record every cycle until back in IDLE.
  task automatic run(input int n, input int limit);
    logic prev_rd;
    in_q.delete(); wt_q.delete(); wr_q.delete(); st_q.delete();
    busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; mac_cnt = 0; clr_cnt = 0; both_cnt = 0;
    irq_cnt = 0; lag_err = 0; clr_orphan = 0; wt_max = 0; rd_cycle = -1; mac_cycle = -1;
    timeout = 1;
    ctrl_start = 1'b0;
    @(posedge aclk); #1;
    pre_done = int'(status_done);
    ctrl_matrix_size = 8'(n);
    ctrl_start = 1'b1;
    prev_rd = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(posedge aclk); #1;
      if (c == 0) begin
        first_state = int'(status_state);
        first_done  = int'(status_done);
        ctrl_matrix_size = 8'd200;
      end
      st_q.push_back(int'(status_state));
      if (status_busy) busy_cnt++;
      if (interrupt) irq_cnt++;
      if (mac_en !== prev_rd) lag_err++;
      if (mac_clear && !mac_en) clr_orphan++;
      if (mac_en) begin mac_cnt++; if (mac_cycle < 0) mac_cycle = c; end
      if (mac_clear) clr_cnt++;
      if (mac_clear && mac_en) both_cnt++;
      if (in_rd_en) begin
        rd_cnt++;
        if (rd_cycle < 0) rd_cycle = c;
        in_q.push_back(int'(in_rd_addr));
        wt_q.push_back(int'(wt_rd_addr));
        if (int'(wt_rd_addr) > wt_max) wt_max = int'(wt_rd_addr);
      end
      if (out_wr_en) begin wr_cnt++; wr_q.push_back(int'(out_wr_addr)); end
      prev_rd = in_rd_en;
      if (c > 0 && status_state == 3'd0) begin timeout = 0; break; end
    end
  endtask

  int exp_in2[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
  int exp_wt2[8] = '{0, 2, 1, 3, 0, 2, 1, 3};
  logic [31:0] perf17, perf4609;

  initial begin
`ifdef NPU_PERF_CNT_EN
    perf17 = 32'd17; perf4609 = 32'd4609;
`else
    perf17 = 32'd0;  perf4609 = 32'd0;
`endif
    areset = 1'b1; ctrl_start = 1'b0; ctrl_reset = 1'b0; ctrl_matrix_size = 8'd0;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_state", 32'(status_state), 0);
    check("rst_strobes", {26'd0, in_rd_en, wt_rd_en, mac_en, mac_clear, out_wr_en, interrupt}, 0);
    check("rst_flags", {29'd0, status_busy, status_done, status_error}, 0);
    check("rst_addr", {6'd0, in_rd_addr, wt_rd_addr, out_wr_addr}, 0);
    check("rst_perf", perf_cycles, 0);
    areset = 1'b0;

    // N=2 full run
    run(2, 100);
    check("n2_timeout", timeout, 0);
    check("n2_first_state", first_state, 1);
    check("n2_busy", busy_cnt, 17);
    check("n2_rd_cnt", rd_cnt, 8);
    for (int e = 0; e < 8; e++) begin
      check($sformatf("n2_in_%0d", e), (e < in_q.size()) ? in_q[e] : -1, exp_in2[e]);
      check($sformatf("n2_wt_%0d", e), (e < wt_q.size()) ? wt_q[e] : -1, exp_wt2[e]);
    end
    check("n2_wr_cnt", wr_cnt, 4);
    for (int e = 0; e < 4; e++)
      check($sformatf("n2_wr_%0d", e), (e < wr_q.size()) ? wr_q[e] : -1, e);
    check("n2_mac_lag", lag_err, 0);
    check("n2_mac_cnt", mac_cnt, 8);
    check("n2_clr_cnt", clr_cnt, 4);
    check("n2_clr_orphan", clr_orphan, 0);
    check("n2_irq", irq_cnt, 1);
    check("n2_done", status_done, 1);
    check("n2_error", status_error, 0);
    check("n2_perf", perf_cycles, perf17);

    // N=1 single element
    run(1, 50);
    check("n1_timeout", timeout, 0);
    check("n1_busy", busy_cnt, 4);
    check("n1_rd_cnt", rd_cnt, 1);
    check("n1_rd_addr", (in_q.size() > 0) ? in_q[0] : -1, 0);
    check("n1_rd_cycle", rd_cycle, 1);
    check("n1_mac_cycle", mac_cycle, 2);
    check("n1_clr_with_en", both_cnt, 1);
    check("n1_wr_addr", (wr_q.size() == 1) ? wr_q[0] : -1, 0);
    check("n1_done", status_done, 1);

    // start held high after DONE must not retrigger
    repeat (5) @(posedge aclk);
    #1;
    check("held_state", 32'(status_state), 0);
    check("held_done", status_done, 1);

    // re-raise: done stays until the edge, then clears
    run(1, 50);
    check("rerun_pre_done", pre_done, 1);
    check("rerun_state", first_state, 1);
    check("rerun_done_clr", first_done, 0);
    check("rerun_done_end", status_done, 1);

    // size errors
    run(0, 50);
    check("n0_timeout", timeout, 0);
    check("n0_seq", (st_q.size() == 3) ? {st_q[0][7:0], st_q[1][7:0], st_q[2][7:0]} : 32'hFFFFFFFF, 32'h010600);
    check("n0_strobes", rd_cnt + wr_cnt + mac_cnt, 0);
    check("n0_error", status_error, 1);
    check("n0_done", status_done, 0);
    check("n0_irq", irq_cnt, 1);
    run(17, 50);
    check("n17_seq", (st_q.size() == 3) ? {st_q[0][7:0], st_q[1][7:0], st_q[2][7:0]} : 32'hFFFFFFFF, 32'h010600);
    check("n17_strobes", rd_cnt + wr_cnt + mac_cnt, 0);
    check("n17_error", status_error, 1);
    check("n17_irq", irq_cnt, 1);

    // N=4, soft abort during element 5 (i=1,j=1) at k=2
    ctrl_start = 1'b0;
    @(posedge aclk); #1;
    ctrl_matrix_size = 8'd4;
    ctrl_start = 1'b1;
    repeat (34) @(posedge aclk);
    #1;
    check("abort_pre_state", 32'(status_state), 2);
    check("abort_pre_in", 32'(in_rd_addr), 6);
    check("abort_pre_wt", 32'(wt_rd_addr), 9);
    ctrl_reset = 1'b1;
    @(posedge aclk); #1;
    ctrl_reset = 1'b0;
    check("abort_state", 32'(status_state), 0);
    check("abort_strobes", {26'd0, in_rd_en, wt_rd_en, mac_en, mac_clear, out_wr_en, interrupt}, 0);
    check("abort_flags", {29'd0, status_busy, status_done, status_error}, 0);
    check("abort_perf", perf_cycles, 0);
    @(posedge aclk); #1;
    check("abort_after", {28'd0, mac_en, mac_clear, interrupt, status_state != 3'd0}, 0);

    // N=16 at MAX_N
    run(16, 5000);
    check("n16_timeout", timeout, 0);
    check("n16_busy", busy_cnt, 4609);
    check("n16_last_wr", (wr_q.size() > 0) ? wr_q[wr_q.size()-1] : -1, 255);
    check("n16_wr_cnt", wr_cnt, 256);
    check("n16_wt_max", wt_max, 255);
    check("n16_mac_lag", lag_err, 0);
    check("n16_irq", irq_cnt, 1);
    check("n16_done", status_done, 1);
    check("n16_perf", perf_cycles, perf4609);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
